// File: rtl/note_combine12.sv
// Octave/note to absolute note number (octave*12 + note) by repeated addition.
// One pair in flight at a time; result held until the consumer takes it.
module note_combine12 (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] octave,
  input  logic [3:0] note,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] note_number,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t     state_q, state_d;
  logic [5:0] acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [5:0] nn_q, nn_d;
  logic       err_q, err_d;
  logic       illegal;

  // Anything that would land above 63 is rejected up front, so acc never wraps.
  assign illegal = (note > 4'd11) || (octave > 3'd5) ||
                   ((octave == 3'd5) && (note > 4'd3));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    nn_d    = nn_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (illegal) begin
            nn_d    = 6'd0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            acc_d = {2'b00, note};
            cnt_d = octave;
            if (octave == 3'd0) begin
              nn_d    = {2'b00, note};
              err_d   = 1'b0;
              state_d = DONE;
            end else begin
              state_d = ACCUM;
            end
          end
        end
      end
      ACCUM: begin
        acc_d = acc_q + 6'd12;
        cnt_d = cnt_q - 3'd1;
        // The published result only changes on entry to DONE.
        if (cnt_q == 3'd1) begin
          nn_d    = acc_q + 6'd12;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= 6'd0;
      cnt_q   <= 3'd0;
      nn_q    <= 6'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      nn_q    <= nn_d;
      err_q   <= err_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign note_number = nn_q;
  assign err         = err_q;

endmodule

// File: doc/note_combine12.md
NOTE_COMBINE12 -- requirements
Module: note_combine12

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port in_valid, input, 1 bit: octave/note pair presented.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts a pair this cycle.
REQ-005 SHALL have port octave, input, 3 bits: octave index, legal 0..5.
REQ-006 SHALL have port note, input, 4 bits: note within octave, legal 0..11.
REQ-007 SHALL have port out_valid, output, 1 bit: result is held on note_number/err.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-009 SHALL have port note_number, output, 6 bits: octave*12 + note, range 0..63.
REQ-010 SHALL have port err, output, 1 bit: the accepted pair was out of range.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE, both decoded from registered state.
REQ-013 SHALL accept a pair on an edge where state=IDLE and in_valid=1; at that edge it SHALL capture octave and note.
REQ-014 SHALL flag a pair as illegal when note>11, octave>5, or octave=5 with note>3 (result >63).
REQ-015 SHALL, on accepting an illegal pair, go to DONE with err=1 and note_number=0; out_valid is high in cycle T+1 (T = accept cycle).
REQ-016 SHALL, on accepting a legal pair, set acc=note and cnt=octave. Next state is DONE if octave=0, otherwise ACCUM.
REQ-017 SHALL, on every ACCUM edge, perform acc<=acc+12 and cnt<=cnt-1. It moves to DONE on the edge where cnt=1.
REQ-018 SHALL give a legal-pair latency of exactly 1+octave cycles: out_valid first high in cycle T+1+octave.
REQ-019 SHALL keep the accumulator 6 bits wide; legal inputs never exceed 63, so no overflow path exists.
REQ-020 SHALL drive note_number from acc, with err=0, for legal pairs.
REQ-021 SHALL hold note_number, err and out_valid stable in DONE while out_ready=0, with no timeout.
REQ-022 SHALL, on an edge with out_valid=1 and out_ready=1, return to IDLE; in_ready is high in the following cycle.
REQ-023 SHALL ignore in_valid in ACCUM and DONE; a producer holding in_valid high is accepted only at the next IDLE.
REQ-024 SHALL ignore out_ready outside DONE.
REQ-025 SHALL leave note_number and err unchanged in IDLE and ACCUM (last result held).
REQ-026 SHALL capture octave/note only at acceptance; input changes during ACCUM SHALL NOT affect the result.

Reset
REQ-027 SHALL, while reset=1 at an edge, force: state=IDLE, acc=0, cnt=0, note_number=0, err=0, out_valid=0, in_ready=1 (from the next cycle).
REQ-028 SHALL give reset priority over every handshake; reset in ACCUM or DONE SHALL discard the in-flight result with no out_valid pulse.
REQ-029 SHALL accept a new pair on the first edge after reset deasserts if in_valid=1.

Verification
REQ-030 SHALL cover: octave=0, note=0, out_ready=1 -> out_valid at T+1, note_number=0, err=0, in_ready high at T+2.
REQ-031 SHALL cover: octave=3, note=7 -> out_valid at T+4, note_number=43, err=0; octave=5, note=3 -> out_valid at T+6, note_number=63.
REQ-032 SHALL cover: octave=5, note=4, then note=12 (octave=0), then octave=6 -> each gives out_valid at T+1, err=1, note_number=0.
REQ-033 SHALL cover: octave=2, note=11 with out_ready=0 for 5 cycles after out_valid -> note_number=35 held stable; in_ready stays 0 until the cycle after out_ready=1.
REQ-034 SHALL cover: reset asserted during ACCUM of octave=4 -> next cycle in_ready=1, out_valid=0, note_number=0; a following octave=1, note=1 yields 13 at T+2.
REQ-035 SHALL cover: exhaustive sweep of all 128 octave/note combinations -> note_number=octave*12+note when legal, err=1 otherwise, with latency per REQ-015/REQ-018.
